// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity modes and the parity helper.
// StBreak exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;

    localparam int unsigned MAX_DATA_W = 9;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
`ifdef UART_TX_BREAK_EN
        StBreak  = 3'd5,
`endif
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } tx_state_e;

    // Unused upper bits of data must be zero; they do not disturb the XOR.
    function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                         input logic [1:0]            mode);
        case (mode)
            PAR_EVEN: return ^data;
            PAR_ODD:  return ~^data;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, flags the last cycle.
// Shared between the UART transmitter and receiver.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tc
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready input, selectable parity and stop bits.
// Define UART_TX_BREAK_EN to add the tx_break input and the BREAK state.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic              tx_clk,
    input  logic              reset,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [1:0]        parity_mode,
    input  logic              two_stop,
`ifdef UART_TX_BREAK_EN
    input  logic              tx_break,
`endif
    output logic              tx_ready,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              tx_serial
);
    localparam int unsigned IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              parity_q, parity_d;
    logic              par_en_q, par_en_d;
    logic              two_stop_q, two_stop_d;
    logic              stop2_q, stop2_d;
    logic              tx_serial_d;
    logic              timer_en;
    logic              bit_end;
    logic              accept;
`ifdef UART_TX_BREAK_EN
    logic              brk_mark_q, brk_mark_d;
`endif

    // A pending break wins over a pending word, so ready drops while break is asserted.
`ifdef UART_TX_BREAK_EN
    assign tx_ready = (state_q == StIdle) && !tx_break;
`else
    assign tx_ready = (state_q == StIdle);
`endif
    assign tx_busy = (state_q != StIdle);
    assign accept  = tx_valid && tx_ready;

    always_comb begin
        timer_en = 1'b0;
        case (state_q)
            StStart, StData, StParity, StStop: timer_en = 1'b1;
`ifdef UART_TX_BREAK_EN
            StBreak: timer_en = brk_mark_q;
`endif
            default: timer_en = 1'b0;
        endcase
    end

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (tx_clk),
        .reset(reset),
        .en   (timer_en),
        .clr  (!timer_en),
        .tc   (bit_end)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        parity_d   = parity_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        stop2_d    = stop2_q;
`ifdef UART_TX_BREAK_EN
        brk_mark_d = brk_mark_q;
`endif
        tx_done    = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d    = StStart;
                    shift_d    = tx_data;
                    idx_d      = '0;
                    parity_d   = calc_parity(MAX_DATA_W'(tx_data), parity_mode);
                    par_en_d   = parity_enabled(parity_mode);
                    two_stop_d = two_stop;
                    stop2_d    = 1'b0;
                end
`ifdef UART_TX_BREAK_EN
                else if (tx_break) begin
                    state_d    = StBreak;
                    brk_mark_d = 1'b0;
                end
`endif
            end
            StStart: begin
                if (bit_end) state_d = StData;
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        state_d = par_en_q ? StParity : StStop;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (bit_end) state_d = StStop;
            end
            StStop: begin
                if (bit_end) begin
                    if (two_stop_q && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        tx_done = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            // Hold low while break is asserted, then one bit time of mark before idle.
            StBreak: begin
                if (!brk_mark_q) begin
                    if (!tx_break) brk_mark_d = 1'b1;
                end else if (bit_end) begin
                    brk_mark_d = 1'b0;
                    state_d    = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // Line is registered and derived from the next state so it changes on the same edge.
        case (state_d)
            StStart:  tx_serial_d = 1'b0;
            StData:   tx_serial_d = shift_d[0];
            StParity: tx_serial_d = parity_d;
`ifdef UART_TX_BREAK_EN
            StBreak:  tx_serial_d = brk_mark_d;
`endif
            default:  tx_serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            idx_q      <= '0;
            parity_q   <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
            tx_serial  <= 1'b1;
`ifdef UART_TX_BREAK_EN
            brk_mark_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            parity_q   <= parity_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            stop2_q    <= stop2_d;
            tx_serial  <= tx_serial_d;
`ifdef UART_TX_BREAK_EN
            brk_mark_q <= brk_mark_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Cycle-accurate bench for uart_tx_param (DATA_W=8, CLKS_PER_BIT=4) using an expected-line queue.
// Define UART_TX_BREAK_EN to also exercise the break feature.
module tb_uart_tx_param;
    localparam int CPB = 4;

    logic       tx_clk = 1'b0;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [1:0] parity_mode;
    logic       two_stop;
`ifdef UART_TX_BREAK_EN
    logic       tx_break;
`endif
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_serial;

    // Per-cycle expectation: {busy, ready, done, serial}
    logic [3:0] exp_q[$];
    logic [3:0] obs_v, exp_v;
    int         errors = 0;
    int         checks = 0;

    uart_tx_param #(
        .DATA_W      (8),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .tx_clk     (tx_clk),
        .reset      (reset),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .parity_mode(parity_mode),
        .two_stop   (two_stop),
`ifdef UART_TX_BREAK_EN
        .tx_break   (tx_break),
`endif
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_serial  (tx_serial)
    );

    always #5 tx_clk = ~tx_clk;

    function automatic void push_frame(input logic [7:0] d, input logic [1:0] m, input logic two);
        logic bq[$];
        bq.push_back(1'b0);
        for (int i = 0; i < 8; i++) bq.push_back(d[i]);
        if (m == 2'b01) bq.push_back(^d);
        else if (m == 2'b10) bq.push_back(~^d);
        bq.push_back(1'b1);
        if (two) bq.push_back(1'b1);
        for (int k = 0; k < bq.size(); k++)
            for (int c = 0; c < CPB; c++)
                exp_q.push_back({1'b1, 1'b0, (k == bq.size() - 1) && (c == CPB - 1), bq[k]});
    endfunction

    function automatic void push_idle();
        exp_q.push_back(4'b0101);
    endfunction

    task automatic test_reset();
        reset = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF; parity_mode = 2'b00; two_stop = 1'b0;
`ifdef UART_TX_BREAK_EN
        tx_break = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge tx_clk);
            obs_v = {tx_busy, tx_ready, tx_done, tx_serial};
            checks++;
            if (obs_v !== 4'b0101) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %b want 0101", i, obs_v);
            end
        end
        tx_valid = 1'b0;
        reset = 1'b0;
        @(negedge tx_clk);
        obs_v = {tx_busy, tx_ready, tx_done, tx_serial};
        checks++;
        if (obs_v !== 4'b0101) begin
            errors++;
            $display("FAIL reset_release: got %b want 0101", obs_v);
        end
    endtask

    task automatic test_even_one_stop();
        tx_data = 8'hA5; parity_mode = 2'b01; two_stop = 1'b0; tx_valid = 1'b1;
        push_frame(8'hA5, 2'b01, 1'b0);
        push_idle();
        @(posedge tx_clk); #1 tx_valid = 1'b0;
        for (int cyc = 1; exp_q.size() > 0; cyc++) begin
            @(negedge tx_clk);
            obs_v = {tx_busy, tx_ready, tx_done, tx_serial};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL even_1stop cycle %0d: got %b want %b", cyc, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_odd_two_stop();
        tx_data = 8'hA5; parity_mode = 2'b10; two_stop = 1'b1; tx_valid = 1'b1;
        push_frame(8'hA5, 2'b10, 1'b1);
        push_idle();
        @(posedge tx_clk); #1 tx_valid = 1'b0;
        for (int cyc = 1; exp_q.size() > 0; cyc++) begin
            @(negedge tx_clk);
            obs_v = {tx_busy, tx_ready, tx_done, tx_serial};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL odd_2stop cycle %0d: got %b want %b", cyc, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        tx_data = 8'h00; parity_mode = 2'b00; two_stop = 1'b0; tx_valid = 1'b1;
        push_frame(8'h00, 2'b00, 1'b0);
        push_idle();
        push_frame(8'hFF, 2'b00, 1'b0);
        push_idle();
        @(posedge tx_clk); #1 tx_data = 8'hFF;
        for (int cyc = 1; exp_q.size() > 0; cyc++) begin
            @(negedge tx_clk);
            obs_v = {tx_busy, tx_ready, tx_done, tx_serial};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %b want %b", cyc, obs_v, exp_v);
            end
            if (exp_q.size() == 20) tx_valid = 1'b0;
        end
    endtask

    task automatic test_midframe_change();
        tx_data = 8'h3C; parity_mode = 2'b01; two_stop = 1'b0; tx_valid = 1'b1;
        push_frame(8'h3C, 2'b01, 1'b0);
        push_idle();
        @(posedge tx_clk);
        #1 tx_data = 8'hC3; parity_mode = 2'b10; two_stop = 1'b1; tx_valid = 1'b0;
        for (int cyc = 1; exp_q.size() > 0; cyc++) begin
            @(negedge tx_clk);
            obs_v = {tx_busy, tx_ready, tx_done, tx_serial};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL midframe_change cycle %0d: got %b want %b", cyc, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_midframe();
        tx_data = 8'hA5; parity_mode = 2'b00; two_stop = 1'b0; tx_valid = 1'b1;
        push_frame(8'hA5, 2'b00, 1'b0);
        @(posedge tx_clk); #1 tx_valid = 1'b0;
        // Cycles 17..20 carry data bit 3; stop after cycle 18.
        for (int cyc = 1; cyc <= 18; cyc++) begin
            @(negedge tx_clk);
            obs_v = {tx_busy, tx_ready, tx_done, tx_serial};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL pre_reset cycle %0d: got %b want %b", cyc, obs_v, exp_v);
            end
        end
        exp_q.delete();
        reset = 1'b1;
        #1;
        checks++;
        if ({tx_busy, tx_serial} !== 2'b01) begin
            errors++;
            $display("FAIL async_reset: got busy/serial %b want 01", {tx_busy, tx_serial});
        end
        @(negedge tx_clk);
        reset = 1'b0;
        tx_data = 8'h5A; parity_mode = 2'b01; tx_valid = 1'b1;
        push_frame(8'h5A, 2'b01, 1'b0);
        push_idle();
        @(posedge tx_clk); #1 tx_valid = 1'b0;
        for (int cyc = 1; exp_q.size() > 0; cyc++) begin
            @(negedge tx_clk);
            obs_v = {tx_busy, tx_ready, tx_done, tx_serial};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL post_reset cycle %0d: got %b want %b", cyc, obs_v, exp_v);
            end
        end
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic test_break();
        tx_break = 1'b1;
        for (int i = 0; i < 20; i++) exp_q.push_back(4'b1000);
        for (int i = 0; i < CPB; i++) exp_q.push_back(4'b1001);
        push_idle();
        for (int cyc = 1; exp_q.size() > 0; cyc++) begin
            @(negedge tx_clk);
            obs_v = {tx_busy, tx_ready, tx_done, tx_serial};
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL break cycle %0d: got %b want %b", cyc, obs_v, exp_v);
            end
            if (cyc == 20) tx_break = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_even_one_stop();
        test_odd_two_stop();
        test_back_to_back();
        test_midframe_change();
        test_reset_midframe();
`ifdef UART_TX_BREAK_EN
        test_break();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
